// File: rtl/regfile_wport_arbiter.sv
// Register-file write-port arbiter: WB has fixed priority, a starved debug write forces a one-cycle stall.
// Optional build macro ARB_STATS_EN adds o_stall_count, a saturating count of forced stalls.
module regfile_wport_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 5,
    parameter int STARVE_LIMIT = 8,
    parameter int CNT_WIDTH    = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_wb_regwrite,
    input  logic [ADDR_WIDTH-1:0] i_wb_addr,
    input  logic [DATA_WIDTH-1:0] i_wb_data,
    input  logic                  i_dbg_req,
    input  logic [ADDR_WIDTH-1:0] i_dbg_addr,
    input  logic [DATA_WIDTH-1:0] i_dbg_data,
    output logic                  o_dbg_ack,
    output logic                  o_stall,
    output logic                  o_rf_we,
    output logic [ADDR_WIDTH-1:0] o_rf_addr,
`ifdef ARB_STATS_EN
    output logic [15:0]           o_stall_count,
`endif
    output logic [DATA_WIDTH-1:0] o_rf_data
);

    localparam logic [1:0] S_PIPE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_STALL = 2'd2;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] LIMIT   = CNT_WIDTH'(STARVE_LIMIT);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > (2**CNT_WIDTH) - 1) begin : g_bad_limit
        $error("STARVE_LIMIT out of range for CNT_WIDTH");
    end

    logic [1:0]                r_state;
    logic [CNT_WIDTH-1:0]      r_cnt;
    logic                      r_stall;
    logic                      r_dbg_ack;
    logic                      r_rf_we;
    logic [ADDR_WIDTH-1:0]     r_rf_addr;
    logic [DATA_WIDTH-1:0]     r_rf_data;

    logic                      w_dbg_req;
    logic                      w_wb_we;
    logic                      w_dbg_we;
    logic [CNT_WIDTH-1:0]      w_cnt_next;
    logic                      w_starved;

    // The ack cycle doubles as the cooldown: a request still high while ack is visible is ignored.
    assign w_dbg_req  = i_dbg_req && !r_dbg_ack;
    assign w_wb_we    = i_wb_regwrite && (i_wb_addr != '0);
    assign w_dbg_we   = (i_dbg_addr != '0);
    assign w_cnt_next = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
    assign w_starved  = (w_cnt_next >= LIMIT);

    // NOTE: all state uses non-blocking assignments so every branch reads pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= S_PIPE;
            r_cnt     <= '0;
            r_stall   <= 1'b0;
            r_dbg_ack <= 1'b0;
            r_rf_we   <= 1'b0;
            r_rf_addr <= '0;
            r_rf_data <= '0;
        end else begin
            r_rf_we   <= 1'b0;
            r_dbg_ack <= 1'b0;
            case (r_state)
                S_PIPE: begin
                    if (i_wb_regwrite) begin
                        r_rf_we   <= w_wb_we;
                        r_rf_addr <= i_wb_addr;
                        r_rf_data <= i_wb_data;
                        if (w_dbg_req) begin
                            r_cnt   <= {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                            r_state <= S_WAIT;
                        end
                    end else if (w_dbg_req) begin
                        r_rf_we   <= w_dbg_we;
                        r_rf_addr <= i_dbg_addr;
                        r_rf_data <= i_dbg_data;
                        r_dbg_ack <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (i_wb_regwrite) begin
                        r_rf_we   <= w_wb_we;
                        r_rf_addr <= i_wb_addr;
                        r_rf_data <= i_wb_data;
                        r_cnt     <= w_cnt_next;
                        if (w_starved) begin
                            r_stall <= 1'b1;
                            r_state <= S_STALL;
                        end
                    end else begin
                        r_rf_we   <= w_dbg_we;
                        r_rf_addr <= i_dbg_addr;
                        r_rf_data <= i_dbg_data;
                        r_dbg_ack <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= S_PIPE;
                    end
                end
                S_STALL: begin
                    // Pipeline is frozen, so WB is ignored; it re-presents its write afterwards.
                    r_rf_we   <= w_dbg_we;
                    r_rf_addr <= i_dbg_addr;
                    r_rf_data <= i_dbg_data;
                    r_dbg_ack <= 1'b1;
                    r_cnt     <= '0;
                    r_stall   <= 1'b0;
                    r_state   <= S_PIPE;
                end
                default: begin
                    r_cnt   <= '0;
                    r_stall <= 1'b0;
                    r_state <= S_PIPE;
                end
            endcase
        end
    end

`ifdef ARB_STATS_EN
    logic [15:0] r_stall_count;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_stall_count <= '0;
        end else if (r_state == S_WAIT && i_wb_regwrite && w_starved
                     && r_stall_count != 16'hFFFF) begin
            r_stall_count <= r_stall_count + 16'd1;
        end
    end

    assign o_stall_count = r_stall_count;
`endif

    assign o_dbg_ack = r_dbg_ack;
    assign o_stall   = r_stall;
    assign o_rf_we   = r_rf_we;
    assign o_rf_addr = r_rf_addr;
    assign o_rf_data = r_rf_data;

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Directed testbench for regfile_wport_arbiter (default parameters, STARVE_LIMIT = 8).
// Build with ARB_STATS_EN defined to also check o_stall_count.
module tb_regfile_wport_arbiter;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_wb_regwrite;
    logic [4:0]  i_wb_addr;
    logic [31:0] i_wb_data;
    logic        i_dbg_req;
    logic [4:0]  i_dbg_addr;
    logic [31:0] i_dbg_data;
    logic        o_dbg_ack;
    logic        o_stall;
    logic        o_rf_we;
    logic [4:0]  o_rf_addr;
    logic [31:0] o_rf_data;
`ifdef ARB_STATS_EN
    logic [15:0] o_stall_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 i_clk = ~i_clk;

    regfile_wport_arbiter dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_wb_regwrite (i_wb_regwrite),
        .i_wb_addr     (i_wb_addr),
        .i_wb_data     (i_wb_data),
        .i_dbg_req     (i_dbg_req),
        .i_dbg_addr    (i_dbg_addr),
        .i_dbg_data    (i_dbg_data),
        .o_dbg_ack     (o_dbg_ack),
        .o_stall       (o_stall),
        .o_rf_we       (o_rf_we),
        .o_rf_addr     (o_rf_addr),
`ifdef ARB_STATS_EN
        .o_stall_count (o_stall_count),
`endif
        .o_rf_data     (o_rf_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle so outputs are sampled away from the edge.
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic we, input logic [4:0] addr,
                             input logic [31:0] data, input logic ack, input logic stall);
        check({tag, ".we"}, 32'(o_rf_we), 32'(we));
        if (we) begin
            check({tag, ".addr"}, 32'(o_rf_addr), 32'(addr));
            check({tag, ".data"}, o_rf_data, data);
        end
        check({tag, ".ack"}, 32'(o_dbg_ack), 32'(ack));
        check({tag, ".stall"}, 32'(o_stall), 32'(stall));
    endtask

    // Debug request held against a continuous WB stream; must start from PIPE with cooldown clear.
    task automatic run_contention(input string tag);
        i_dbg_req     = 1'b1;
        i_dbg_addr    = 5'd9;
        i_dbg_data    = 32'h0000_AAAA;
        i_wb_regwrite = 1'b1;
        i_wb_addr     = 5'd3;
        for (int i = 0; i < 8; i++) begin
            i_wb_data = 32'(i);
            step();
            // The 8th blocked WB write is the one that trips the starvation limit.
            check_out($sformatf("%s.wb%0d", tag, i), 1'b1, 5'd3, 32'(i), 1'b0, (i == 7));
        end
        i_wb_data = 32'h0000_0099;
        step();
        check_out({tag, ".dbg"}, 1'b1, 5'd9, 32'h0000_AAAA, 1'b1, 1'b0);
        i_dbg_req = 1'b0;
        i_wb_data = 32'h0000_005A;
        step();
        check_out({tag, ".resume"}, 1'b1, 5'd3, 32'h0000_005A, 1'b0, 1'b0);
        i_wb_regwrite = 1'b0;
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        i_reset       = 1'b1;
        i_wb_regwrite = 1'b0;
        i_wb_addr     = '0;
        i_wb_data     = '0;
        i_dbg_req     = 1'b0;
        i_dbg_addr    = '0;
        i_dbg_data    = '0;
        step();
        step();
        check("rst.we",    32'(o_rf_we),   32'd0);
        check("rst.addr",  32'(o_rf_addr), 32'd0);
        check("rst.data",  o_rf_data,      32'd0);
        check("rst.ack",   32'(o_dbg_ack), 32'd0);
        check("rst.stall", 32'(o_stall),   32'd0);
`ifdef ARB_STATS_EN
        check("rst.count", 32'(o_stall_count), 32'd0);
`endif
        i_reset = 1'b0;

        // 1. WB only
        i_wb_regwrite = 1'b1;
        i_wb_addr     = 5'd5;
        i_wb_data     = 32'h0000_CAFE;
        step();
        check_out("wb_only", 1'b1, 5'd5, 32'h0000_CAFE, 1'b0, 1'b0);
        i_wb_regwrite = 1'b0;
        step();
        check_out("wb_only.idle", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);

        // 2. Debug only, request held one cycle past the ack
        i_dbg_req  = 1'b1;
        i_dbg_addr = 5'd7;
        i_dbg_data = 32'h0000_1234;
        step();
        check_out("dbg_only", 1'b1, 5'd7, 32'h0000_1234, 1'b1, 1'b0);
        step();
        check_out("dbg_only.cool", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        i_dbg_req = 1'b0;
        step();
        check_out("dbg_only.idle", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);

        // 3. Contention up to a forced stall
        run_contention("starve");
`ifdef ARB_STATS_EN
        check("starve.count", 32'(o_stall_count), 32'd1);
`endif

        // 4. WB burst with a gap on the third cycle
        i_dbg_req     = 1'b1;
        i_dbg_addr    = 5'd11;
        i_dbg_data    = 32'h0000_BEEF;
        i_wb_regwrite = 1'b1;
        i_wb_addr     = 5'd4;
        i_wb_data     = 32'h0000_0010;
        step();
        check_out("gap.wb0", 1'b1, 5'd4, 32'h0000_0010, 1'b0, 1'b0);
        i_wb_data = 32'h0000_0011;
        step();
        check_out("gap.wb1", 1'b1, 5'd4, 32'h0000_0011, 1'b0, 1'b0);
        i_wb_regwrite = 1'b0;
        step();
        check_out("gap.dbg", 1'b1, 5'd11, 32'h0000_BEEF, 1'b1, 1'b0);
        i_dbg_req = 1'b0;
        step();
        check_out("gap.idle", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);

        // 5. Register 0 from both sources
        i_wb_regwrite = 1'b1;
        i_wb_addr     = 5'd0;
        i_wb_data     = 32'h0000_0055;
        step();
        check_out("r0.wb", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        i_wb_regwrite = 1'b0;
        i_dbg_req     = 1'b1;
        i_dbg_addr    = 5'd0;
        i_dbg_data    = 32'h0000_0066;
        step();
        check_out("r0.dbg", 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
        i_dbg_req = 1'b0;
        step();
        check_out("r0.idle", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);

        // 6. Reset while waiting with the counter at 5
        i_dbg_req     = 1'b1;
        i_dbg_addr    = 5'd13;
        i_dbg_data    = 32'h0000_0077;
        i_wb_regwrite = 1'b1;
        i_wb_addr     = 5'd2;
        i_wb_data     = 32'h0000_0020;
        for (int i = 0; i < 5; i++) begin
            step();
        end
        check_out("wait5", 1'b1, 5'd2, 32'h0000_0020, 1'b0, 1'b0);
        i_reset       = 1'b1;
        i_wb_regwrite = 1'b0;
        step();
        check("rrst.we",   32'(o_rf_we),   32'd0);
        check("rrst.addr", 32'(o_rf_addr), 32'd0);
        check("rrst.data", o_rf_data,      32'd0);
        check("rrst.ack",  32'(o_dbg_ack), 32'd0);
        check("rrst.stall", 32'(o_stall),  32'd0);
        i_reset = 1'b0;
        step();
        check_out("rrst.served", 1'b1, 5'd13, 32'h0000_0077, 1'b1, 1'b0);
        i_dbg_req = 1'b0;
        step();

        // A fresh counter must again allow exactly eight blocked WB writes.
        run_contention("fresh");
`ifdef ARB_STATS_EN
        check("fresh.count", 32'(o_stall_count), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
